// File: rtl/clock_div_gf_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_div_gf_if
//  Purpose  : Control/status bundle for the glitch-free integer-N clock
//             divider. The master side issues the run request and divisor
//             changes. The slave side (the divider) returns the handshake,
//             the active divisor, the period tick and the divided clock.
//  Signals  : enable  - run request (master -> slave)
//             n_in    - requested divisor (master -> slave)
//             n_load  - divisor-change request, level (master -> slave)
//             n_ack   - one-clk acceptance pulse (slave -> master)
//             n_cur   - divisor currently in use (slave -> master)
//             tick    - first-cycle-of-period strobe (slave -> master)
//             out     - divided clock (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface clock_div_gf_if #(
  parameter int SIZE = 8
);
  logic            enable;
  logic [SIZE-1:0] n_in;
  logic            n_load;
  logic            n_ack;
  logic [SIZE-1:0] n_cur;
  logic            tick;
  logic            out;

  modport master (
    output enable, n_in, n_load,
    input  n_ack, n_cur, tick, out
  );

  modport slave (
    input  enable, n_in, n_load,
    output n_ack, n_cur, tick, out
  );
endinterface
`default_nettype wire

// File: rtl/clock_div_gf.sv
`default_nettype none
// ============================================================================
//  Module   : clock_div_gf
//  Purpose  : Parametrised glitch-free integer-N clock divider with 50% duty
//             for odd and even divisors, run enable with clean park-low,
//             per-period tick and a divisor-change handshake that takes
//             effect only on an output-period boundary.
//  Ports    : clk    - source clock (posedge primary, negedge for odd half)
//             resetb - asynchronous active-low reset
//             bus    - clock_div_gf_if slave modport (enable, n_in, n_load,
//                      n_ack, n_cur, tick, out)
//  Revision : 1.0  initial release
// ============================================================================
module clock_div_gf #(
  parameter int SIZE      = 8,
  parameter int DEFAULT_N = 2
) (
  input  wire logic      clk,
  input  wire logic      resetb,
  clock_div_gf_if.slave  bus
);

  localparam logic [SIZE-1:0] c_default_n = SIZE'(DEFAULT_N);

  // Divisors 0 and 1 both mean bypass.
  function automatic logic [SIZE-1:0] eff_div(input logic [SIZE-1:0] n);
    return (n < SIZE'(2)) ? SIZE'(1) : n;
  endfunction

  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] n_cur_q, n_cur_d;
  logic            running_q, running_d;
  logic            n_ack_q, n_ack_d;
  logic            hi_p_q, hi_p_d;
  logic            hi_n_q;

  logic [SIZE-1:0] d_cur;
  logic [SIZE-1:0] d_nxt;
  logic [SIZE-1:0] h_nxt;
  logic            boundary;
  logic            bypass_cur;
  logic            odd_cur;

  always_comb begin
    d_cur      = eff_div(n_cur_q);
    bypass_cur = (d_cur == SIZE'(1));
    odd_cur    = d_cur[0] & ~bypass_cur;
    // In bypass d_cur-1 is 0 and cnt holds 0, so every edge is a boundary.
    boundary   = ~running_q | (cnt_q == (d_cur - SIZE'(1)));

    n_cur_d   = n_cur_q;
    n_ack_d   = 1'b0;
    running_d = running_q;
    cnt_d     = cnt_q + SIZE'(1);

    if (boundary) begin
      cnt_d     = '0;
      running_d = bus.enable;
      if (bus.n_load) begin
        n_cur_d = bus.n_in;
        n_ack_d = 1'b1;
      end
    end

    // High phase is decided with the divisor that the coming cycle belongs
    // to, so a new divisor shapes its very first period. D=1 gives H=0 and
    // keeps hi_p low; bypass output comes from clk directly.
    d_nxt  = eff_div(n_cur_d);
    h_nxt  = d_nxt >> 1;
    hi_p_d = running_d & (cnt_d < h_nxt);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q     <= '0;
      n_cur_q   <= c_default_n;
      running_q <= 1'b0;
      n_ack_q   <= 1'b0;
      hi_p_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_cur_q   <= n_cur_d;
      running_q <= running_d;
      n_ack_q   <= n_ack_d;
      hi_p_q    <= hi_p_d;
    end
  end

  // Half-cycle extension for odd divisors. Gating with odd_cur clears it on
  // the boundary negedge whenever the new divisor is even or bypass; hi_p is
  // always low in the last cycle of a period, so no stale high carries over.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      hi_n_q <= 1'b0;
    end else begin
      hi_n_q <= hi_p_q & odd_cur;
    end
  end

  assign bus.out   = hi_p_q | (hi_n_q & odd_cur) | (clk & running_q & bypass_cur);
  assign bus.tick  = running_q & (cnt_q == '0);
  assign bus.n_ack = n_ack_q;
  assign bus.n_cur = n_cur_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_gf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_div_gf
//  Purpose  : Self-checking bench for clock_div_gf. A period-level reference
//             model builds each output period as a list of half-cycle levels
//             (D half-cycles high then D low) and is compared against the
//             DUT in the middle of every clk half.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_div_gf;

  localparam int SIZE      = 8;
  localparam int DEFAULT_N = 2;

  logic clk;
  logic resetb;

  clock_div_gf_if #(.SIZE(SIZE)) bus ();

  clock_div_gf #(
    .SIZE      (SIZE),
    .DEFAULT_N (DEFAULT_N)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one queue entry per clk cycle of the current period.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic h0;  // out level in first (high-clk) half
    logic h1;  // out level in second (low-clk) half
    logic tk;  // tick expected this cycle
  } slot_t;

  slot_t           q[$];
  slot_t           cur;
  logic [SIZE-1:0] m_n;
  logic            m_ack;

  task automatic model_reset();
    q.delete();
    m_n   = SIZE'(DEFAULT_N);
    cur   = '0;
    m_ack = 1'b0;
  endtask

  initial begin
    int d;
    model_reset();
    forever begin
      @(posedge clk);
      m_ack = 1'b0;
      if (!resetb) begin
        model_reset();
      end else begin
        if (q.size() == 0) begin
          if (bus.n_load) begin
            m_n   = bus.n_in;
            m_ack = 1'b1;
          end
          if (bus.enable) begin
            d = (m_n < 2) ? 1 : int'(m_n);
            for (int c = 0; c < d; c++) begin
              slot_t s;
              s.h0 = (2 * c < d);
              s.h1 = (2 * c + 1 < d);
              s.tk = (c == 0);
              q.push_back(s);
            end
          end else begin
            q.push_back(slot_t'(0));
          end
        end
        cur = q.pop_front();
      end
      #2;
      if (!resetb) begin
        model_reset();
        check_eq("out_rst", bus.out, 0);
        check_eq("tick_rst", bus.tick, 0);
        check_eq("ack_rst", bus.n_ack, 0);
        check_eq("ncur_rst", bus.n_cur, DEFAULT_N);
      end else begin
        check_eq("out_hi_half", bus.out, cur.h0);
        check_eq("tick", bus.tick, cur.tk);
        check_eq("n_ack", bus.n_ack, m_ack);
        check_eq("n_cur", bus.n_cur, m_n);
      end
      @(negedge clk);
      #2;
      if (!resetb) begin
        model_reset();
        check_eq("out_rst_neg", bus.out, 0);
      end else begin
        check_eq("out_lo_half", bus.out, cur.h1);
      end
    end
  end

  // n_in must stay stable while a request is pending.
  logic [SIZE-1:0] prev_n_in;
  logic            prev_load;
  always @(posedge clk) begin
    if (resetb && bus.n_load && prev_load && (bus.n_in != prev_n_in))
      $error("n_in changed while n_load high");
    prev_n_in = bus.n_in;
    prev_load = bus.n_load;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic load_n(input logic [SIZE-1:0] v, input bit hold_extra);
    bit got = 1'b0;
    @(negedge clk); #1;
    bus.n_in   = v;
    bus.n_load = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.n_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("ack_timeout", 0, 1);
    if (hold_extra) @(negedge clk);
    #1 bus.n_load = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_enable(input logic e);
    @(negedge clk); #1;
    bus.enable = e;
  endtask

  initial begin
    logic [SIZE-1:0] v;
    resetb     = 1'b0;
    bus.enable = 1'b1;
    bus.n_in   = '0;
    bus.n_load = 1'b0;
    repeat (3) @(negedge clk);
    #3 resetb = 1'b1;

    wait_cycles(8);                 // default D=2
    load_n(8'd4, 1'b0);
    wait_cycles(12);
    load_n(8'd5, 1'b0);
    wait_cycles(15);
    load_n(8'd4, 1'b0);
    load_n(8'd7, 1'b0);             // requested mid-period
    wait_cycles(16);

    load_n(8'd6, 1'b0);
    wait_cycles(1);
    bus.enable = 1'b0;              // drop mid-high phase
    wait_cycles(10);
    bus.enable = 1'b1;
    wait_cycles(14);

    load_n(8'd1, 1'b0);
    wait_cycles(5);
    load_n(8'd0, 1'b1);             // held one extra cycle: re-ack in bypass
    wait_cycles(5);
    load_n(8'd3, 1'b0);
    wait_cycles(9);

    // Simultaneous load and stop, then parked load.
    @(negedge clk); #1;
    bus.enable = 1'b0;
    load_n(8'd9, 1'b0);
    wait_cycles(12);
    load_n(8'd2, 1'b0);
    set_enable(1'b1);
    wait_cycles(6);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          v = ($urandom_range(0, 7) == 0) ? SIZE'($urandom_range(0, 1))
                                          : SIZE'($urandom_range(2, 12));
          load_n(v, bit'($urandom_range(0, 3) == 0));
        end
        1: set_enable(logic'($urandom_range(0, 1)));
        2: wait_cycles($urandom_range(1, 20));
        default: begin
          set_enable(logic'($urandom_range(0, 1)));
          load_n(SIZE'($urandom_range(1, 11)), 1'b0);
        end
      endcase
    end
    set_enable(1'b1);

    load_n(8'd255, 1'b0);
    wait_cycles(300);
    @(posedge clk);
    #3 resetb = 1'b0;               // mid-period, inside the high phase
    #1;
    check_eq("async_rst_out", bus.out, 0);
    check_eq("async_rst_ncur", bus.n_cur, DEFAULT_N);
    check_eq("async_rst_tick", bus.tick, 0);
    @(negedge clk);
    #3 resetb = 1'b1;
    wait_cycles(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/clock_div_gf.md
Name: clock_div_gf

Overview:
- Parametrised, glitch-free integer-N clock divider. Successor to the existing 3-bit even/odd divider pair: wider divisor, 50% duty for odd and even N, and divisor changes via a handshake that take effect only on an output-period boundary.
- Generates housekeeping and peripheral clocks from the core clock.
- Adds a run enable with clean park-low, and a per-period tick strobe.

Parameters:
- SIZE, 8, divisor width; legal divisors 1..2^SIZE-1.
- DEFAULT_N, 2, divisor loaded at reset; must be < 2^SIZE.

Ports:
- clk  input  1  source clock; posedge is primary, negedge is used only for the odd half-cycle flop.
- resetb  input  1  reset, asynchronous, active-low.
- enable  input  1  run request, sampled on posedge.
- n_in  input  SIZE  requested divisor; must be stable while n_load is high.
- n_load  input  1  divisor-change request (level); held until n_ack.
- n_ack  output  1  one-clk pulse; new divisor takes effect this period.
- n_cur  output  SIZE  divisor currently in use, raw value as loaded.
- tick  output  1  posedge-domain pulse in the first clk cycle of each output period.
- out  output  1  divided clock.

Behaviour:
- Reset (async, resetb=0):
  - cnt=0, n_cur=DEFAULT_N.
  - out=0, n_ack=0, tick=0.
  - hi_p=0, hi_n=0, running=0.
  - out falls immediately on reset assertion; this is the only permitted short pulse.
- Effective divisor D = n_cur, with n_cur in {0,1} treated as D=1 (bypass).
- Divided mode (D>=2):
  - cnt counts 0..D-1 on posedge and wraps to 0.
  - H = floor(D/2).
  - hi_p (posedge flop) is 1 during cycles with cnt < H.
  - hi_n (negedge flop) samples hi_p; it is used only when D is odd.
  - out = hi_p | (hi_n & D[0]).
  - Even D: high H cycles, low H cycles.
  - Odd D: high H+0.5 cycles, low H+0.5 cycles.
  - out rises on the posedge where cnt goes to 0.
- Bypass (D=1): out = clk & running; tick=1 every cycle while running.
- Boundary: the posedge at which cnt would wrap to 0 (cnt==D-1, or every edge in bypass, or any edge while parked).
- Start-up:
  - running sets on the first posedge with enable=1.
  - The first out rise occurs on that same edge in divided mode; tick pulses for that cycle.
- Stop:
  - enable=0 is honoured only at a boundary.
  - The current period completes fully; then running=0, cnt holds 0, and out parks low.
  - No truncated high or low phase.
- Divisor change:
  - When n_load=1 at a boundary, n_cur<=n_in on that edge and n_ack=1 for exactly that cycle.
  - The next period uses the new D.
  - n_load asserted mid-period waits; no ack until the boundary.
  - n_load must drop the cycle after n_ack. If n_load is still high, it is treated as a new request at the next boundary (re-ack allowed).
  - n_in changing while n_load=1 is illegal (assertion in bench).
- Parked load: while running=0, any posedge is a boundary; the load is accepted in 1 cycle.
- Simultaneous load and stop at the same boundary: the load is accepted and the stop is honoured. n_cur updates, out stays parked.
- Bypass↔divided switching: at a boundary clk is rising and out is rising in both modes, so no glitch.
  - hi_n is cleared on the boundary negedge when the new D is even or 1.
- Odd→even switching: hi_n must be 0 before the new period's first fall. This is guaranteed because hi_p=0 in the last cycle of any period with D>=2.
- Arithmetic:
  - cnt, H, and compares are SIZE bits with no overflow; D-1 max is 2^SIZE-2.
  - tick is combinational from cnt==0 & running, registered-clean.
- Minimum out high or low width: 0.5 clk (D=1). No pulse narrower than min(old, new) half-period at any change.

Test Plan:
- Reset with DEFAULT_N=2, enable=1 → out period 2 clk, high 1 clk; n_cur=2; tick every 2nd clk; all outputs 0 during resetb=0.
- n_in=4 loaded → period 4, high exactly 2 clk. Then n_in=5 → high 2.5 clk (rise on posedge, fall on negedge), period 5, duty measured 50%.
- Load 4→7 asserted at cnt=1 → n_ack only at the cnt==3 boundary; no out edge between boundaries other than the normal fall; following period is 7.
- Drop enable mid-high-phase with D=6 → period completes (3 high, 3 low), out stays 0. Re-enable → out rises on the first posedge with enable=1, tick=1.
- Bypass: n_in=1 and n_in=0 → out follows clk. Switch 1→3 → first divided period starts on the ack edge, high 1.5 clk, no runt pulse.
- SIZE=8, n_in=255 → period 255, high 127.5 clk. Assert resetb=0 mid-period → out 0 immediately, n_cur=DEFAULT_N.
